display_driver: RTL and testbench



---
 rtl/mips_display_pkg.sv | 23 ++
 rtl/bin2bcd_serial.sv | 61 ++++++
 rtl/display_driver.sv | 102 ++++++++++
 tb/tb_display_driver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_display_pkg.sv
// Shared types and constants for the CPU display path: conversion FSM states,
// BCD sizing and the active-low segment patterns.
package mips_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  localparam int BCD_DIGITS   = 10;
  localparam int SHIFT_CYCLES = 32;

  // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    if (nib <= 4'd9) return SEG_DIGIT[nib];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per clock, 32 steps per
// conversion, with a one-cycle DONE state during which bcd holds the result.
module bin2bcd_serial
  import mips_display_pkg::*;
(
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic [39:0] bcd,
  output logic        done
);

  conv_state_t state;
  logic [31:0] sreg;
  logic [4:0]  cnt;
  logic [39:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg  <= value;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, sreg} <= {bcd_adj, sreg} << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(SHIFT_CYCLES - 1)) state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);

endmodule

// File: rtl/display_driver.sv
// Multiplexed 7-segment driver for the CPU display word: converts on change,
// latches complete results only, and scans digits with leading-zero blanking.
module display_driver
  import mips_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk_fpga,
  input  logic                  reset,
  input  logic [31:0]           value,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n,
  output logic                  busy,
  output logic                  overflow
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [31:0]             shadow;
  logic                    start;
  logic                    conv_done;
  logic [39:0]             bcd;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    ovf_next;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic                    lead_blank;
  logic [3:0]              cur_digit;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  // busy is high through SHIFT and DONE, so !busy means the converter is idle.
  assign start = !busy && (value != shadow);

  bin2bcd_serial u_conv (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .bcd      (bcd),
    .done     (conv_done)
  );

  always_comb begin
    ovf_next = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      shadow   <= '0;
      digits   <= '0;
      overflow <= 1'b0;
    end else begin
      if (start) shadow <= value;
      if (conv_done) begin
        digits   <= bcd[4*NUM_DIGITS-1:0];
        overflow <= ovf_next;
      end
    end
  end

  // A digit is blank when it and every more-significant digit are zero,
  // except the units digit which always shows.
  always_comb begin
    lead_blank = (idx != '0);
    cur_digit  = 4'd0;
    an_next    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && digits[4*i +: 4] != 4'd0) lead_blank = 1'b0;
      if (i == int'(idx)) begin
        cur_digit  = digits[4*i +: 4];
        an_next[i] = 1'b0;
      end
    end
    if (overflow)        seg_next = SEG_DASH;
    else if (lead_blank) seg_next = SEG_BLANK;
    else                 seg_next = seg_decode(cur_digit);
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      an_n  <= an_next;
      seg_n <= seg_next;
      idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

endmodule

// File: tb/tb_display_driver.sv
// Scoreboard bench for display_driver: expected displays are queued when a
// value is applied and compared once the converter reports completion.
module tb_display_driver;

  localparam int NUM_DIGITS = 8;
  localparam int SCAN_DIV   = 4;

  typedef struct packed {
    logic            ovf;
    logic [7:0][6:0] segs;
  } exp_t;

  logic        clk_fpga = 1'b0;
  logic        reset    = 1'b0;
  logic [31:0] value    = '0;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        busy;
  logic        overflow;

  int   error_count = 0;
  int   check_count = 0;
  exp_t sb_queue[$];
  exp_t e5, e77, ecur;

  display_driver #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .value    (value),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference built from division, independent of the shift engine.
  function automatic exp_t model(input logic [31:0] v);
    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    longint unsigned x = 64'(v);
    exp_t e;
    e.ovf = (x >= 64'd100000000);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (e.ovf)                e.segs[i] = 7'h3F;
      else if (i > 0 && x == 0) e.segs[i] = 7'h7F;
      else                      e.segs[i] = tab[x % 10];
      x = x / 10;
    end
    return e;
  endfunction

  task automatic apply_stimulus(input logic [31:0] v);
    value = v;
    sb_queue.push_back(model(v));
  endtask

  task automatic wait_conversion(input string tag, input int exp_ticks);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 200);
    check_output({tag, " latency"}, 64'(n), 64'(exp_ticks));
  endtask

  task automatic check_latch(input string tag, output exp_t e);
    e = '0;
    if (sb_queue.size() > 0) e = sb_queue.pop_front();
    check_output({tag, " overflow"}, 64'(overflow), 64'(e.ovf));
  endtask

  task automatic check_scan(input string tag, input exp_t e, input int n);
    logic [7:0] seen = '0;
    int zeros;
    repeat (SCAN_DIV) tick();
    for (int t = 0; t < n; t++) begin
      tick();
      zeros = $countones(~an_n);
      check_output({tag, " onehot"}, 64'(zeros), 64'd1);
      if (zeros == 1) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!an_n[i]) begin
            seen[i] = 1'b1;
            check_output($sformatf("%s seg%0d", tag, i), 64'(seg_n), 64'(e.segs[i]));
          end
        end
      end
    end
    if (n >= NUM_DIGITS * SCAN_DIV) check_output({tag, " coverage"}, 64'(seen), 64'hFF);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    value = 32'd0;
    reset = 1'b0;
    repeat (3) tick();
    check_output("reset an_n", 64'(an_n), 64'hFF);
    check_output("reset seg_n", 64'(seg_n), 64'h7F);
    reset = 1'b1;

    for (int k = 1; k <= 3; k++) begin
      tick();
      check_output($sformatf("prescan an_n %0d", k), 64'(an_n), 64'hFF);
      check_output("idle busy", 64'(busy), 64'd0);
    end
    tick();
    check_output("first an_n", 64'(an_n), 64'hFE);
    check_output("first seg_n", 64'(seg_n), 64'h40);
    repeat (4) tick();
    check_output("second an_n", 64'(an_n), 64'hFD);
    check_output("second seg_n", 64'(seg_n), 64'h7F);
    check_scan("zero", model(32'd0), 32);
    check_output("zero busy", 64'(busy), 64'd0);

    apply_stimulus(32'd1234);
    wait_conversion("1234", 34);
    check_latch("1234", ecur);
    check_scan("1234", ecur, 32);

    apply_stimulus(32'd99999999);
    wait_conversion("nines", 34);
    check_latch("nines", ecur);
    check_scan("nines", ecur, 32);

    apply_stimulus(32'd100000000);
    wait_conversion("ovf", 34);
    check_latch("ovf", ecur);
    check_scan("ovf", ecur, 32);

    // Change arrives ten edges into the first conversion.
    apply_stimulus(32'd5);
    repeat (10) tick();
    apply_stimulus(32'd77);
    wait_conversion("mid5", 24);
    check_latch("mid5", e5);
    tick();
    check_output("retrigger busy", 64'(busy), 64'd1);
    check_scan("mid5", e5, 28);
    wait_conversion("mid77", 1);
    check_latch("mid77", e77);
    check_scan("mid77", e77, 32);

    apply_stimulus(32'd123456);
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    void'(sb_queue.pop_back());
    check_output("abort busy", 64'(busy), 64'd0);
    check_output("abort an_n", 64'(an_n), 64'hFF);
    check_output("abort seg_n", 64'(seg_n), 64'h7F);
    check_output("abort overflow", 64'(overflow), 64'd0);
    apply_stimulus(32'd42);
    tick();
    reset = 1'b1;
    wait_conversion("rst42", 34);
    check_latch("rst42", ecur);
    check_scan("rst42", ecur, 32);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
